pick_stream: RTL and testbench

- Parametrised successor of the single-width pixel picker.
- Hunts a 16..N-bit input stream for a preamble/sync header, then captures a fixed-length pixel line.
- Optional stride decimation selects which captured words are kept.
- Kept words are buffered in an internal FIFO and drained to a downstream sink with PUSH/PIXEL_READY backpressure; sits between the raw sensor word stream and the pixel line store.

---
 rtl/pick_pkg.sv | 18 +
 rtl/pick_stream_if.sv | 20 ++
 rtl/pick_fifo.sv | 53 +++++
 rtl/pick_stream.sv | 125 ++++++++++++
 tb/tb_pick_stream.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pick_pkg.sv
// Shared types and constants for the pick_stream line capture block.
package pick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic [15:0] PRE_WORD_DEF  = 16'hFFFF;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hAAAA;

  // Address bits plus one wrap bit to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pick_stream_if.sv
// Raw word stream in, pixel stream out; master is the sensor/sink side, slave is the picker.
interface pick_stream_if #(
  parameter int DW = 16
);
  logic          DIN_VALID;
  logic [DW-1:0] DIN;
  logic          PIXEL_READY;
  logic          PUSH;
  logic [DW-1:0] PIXEL_DATA;

  modport master (
    output DIN_VALID, DIN, PIXEL_READY,
    input  PUSH, PIXEL_DATA
  );

  modport slave (
    input  DIN_VALID, DIN, PIXEL_READY,
    output PUSH, PIXEL_DATA
  );
endinterface

// File: rtl/pick_fifo.sv
// Synchronous FIFO whose head word is held in a register, so a write is visible one cycle later.
module pick_fifo
  import pick_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next;
  logic [DW-1:0] rd_data_reg;

  assign empty       = (wr_ptr_reg == rd_ptr_reg);
  assign full        = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign wr_ptr_next = wr_en ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
  assign rd_ptr_next = rd_en ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
  assign rd_data     = rd_data_reg;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  // Preload the next head; bypass when that head is the word being written now.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rd_data_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (wr_ptr_next != rd_ptr_next) begin
        if (wr_en && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]))
          rd_data_reg <= wr_data;
        else
          rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/pick_stream.sv
// Hunts a preamble/sync header, captures one stride-decimated pixel line and
// drains it through an output FIFO with ready backpressure.
module pick_stream
  import pick_pkg::*;
#(
  parameter int            DW        = 16,
  parameter logic [DW-1:0] PRE_WORD  = DW'(PRE_WORD_DEF),
  parameter int            PRE_LEN   = 2,
  parameter logic [DW-1:0] SYNC_WORD = DW'(SYNC_WORD_DEF),
  parameter int            PIXELS    = 16,
  parameter int            DEPTH     = 8,
  parameter int            SW        = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          GO,
  input  logic [SW-1:0] STRIDE,
  pick_stream_if.slave  bus,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVERFLOW
);
  localparam int PCW = $clog2(PRE_LEN + 1);
  localparam int WCW = $clog2(PIXELS + 1);

  state_t         state_reg, state_next;
  logic [PCW-1:0] pre_cnt_reg, pre_cnt_next;
  logic [WCW-1:0] word_cnt_reg, word_cnt_next;
  logic [SW-1:0]  phase_reg, phase_next;
  logic [SW-1:0]  stride_reg, stride_next;
  logic           overflow_reg, overflow_next;
  logic [SW:0]    phase_inc;
  logic           keep, last_word;
  logic           fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [DW-1:0]  fifo_rd_data;

  assign fifo_rd   = !fifo_empty && bus.PIXEL_READY;
  assign keep      = (state_reg == ST_CAPTURE) && bus.DIN_VALID && (phase_reg == '0);
  assign fifo_wr   = keep && (!fifo_full || fifo_rd);
  assign last_word = (state_reg == ST_CAPTURE) && bus.DIN_VALID && (word_cnt_reg == WCW'(PIXELS - 1));
  assign phase_inc = {1'b0, phase_reg} + (SW+1)'(1);

  always_comb begin
    state_next    = state_reg;
    pre_cnt_next  = pre_cnt_reg;
    word_cnt_next = word_cnt_reg;
    phase_next    = phase_reg;
    stride_next   = stride_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      ST_IDLE: begin
        if (GO) begin
          state_next    = ST_HUNT;
          pre_cnt_next  = '0;
          overflow_next = 1'b0;
        end
      end
      ST_HUNT: begin
        if (!GO) begin
          state_next = ST_IDLE;
        end else if (bus.DIN_VALID) begin
          // Preamble counting wins until saturated, so PRE_WORD==SYNC_WORD still works.
          if (bus.DIN == PRE_WORD && pre_cnt_reg != PCW'(PRE_LEN)) begin
            pre_cnt_next = pre_cnt_reg + PCW'(1);
          end else if (bus.DIN == SYNC_WORD && pre_cnt_reg == PCW'(PRE_LEN)) begin
            state_next    = ST_CAPTURE;
            stride_next   = (STRIDE == '0) ? SW'(1) : STRIDE;
            word_cnt_next = '0;
            phase_next    = '0;
          end else if (bus.DIN != PRE_WORD) begin
            pre_cnt_next = '0;
          end
        end
      end
      ST_CAPTURE: begin
        if (bus.DIN_VALID) begin
          word_cnt_next = word_cnt_reg + WCW'(1);
          phase_next    = (phase_inc == {1'b0, stride_reg}) ? '0 : phase_inc[SW-1:0];
          if (last_word) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (keep && fifo_full && !fifo_rd) overflow_next = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      pre_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      phase_reg    <= '0;
      stride_reg   <= SW'(1);
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pre_cnt_reg  <= pre_cnt_next;
      word_cnt_reg <= word_cnt_next;
      phase_reg    <= phase_next;
      stride_reg   <= stride_next;
      overflow_reg <= overflow_next;
    end
  end

  pick_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (fifo_wr),
    .wr_data (bus.DIN),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.PUSH       = !fifo_empty;
  assign bus.PIXEL_DATA = fifo_rd_data;
  assign BUSY           = (state_reg != ST_IDLE);
  assign DONE           = last_word;
  assign OVERFLOW       = overflow_reg;

endmodule

// File: tb/tb_pick_stream.sv
// Bench for pick_stream: scenario table, hand-written corner sequences and random
// streams, all checked each cycle against a queue-based line model.
module tb_pick_stream;
  localparam int          DW      = 16;
  localparam int          PRE_LEN = 2;
  localparam int          PIXELS  = 16;
  localparam int          DEPTH   = 8;
  localparam logic [15:0] PRE     = 16'hFFFF;
  localparam logic [15:0] SYNC    = 16'hAAAA;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       GO    = 1'b0;
  logic [3:0] STRIDE = 4'd1;
  logic       BUSY, DONE, OVERFLOW;

  pick_stream_if #(.DW(DW)) bus_if ();

  pick_stream dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .GO       (GO),
    .STRIDE   (STRIDE),
    .bus      (bus_if),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 hunting, 2 capturing; the FIFO is a plain queue.
  int          m_mode   = 0;
  int          m_run    = 0;
  int          m_idx    = 0;
  int          m_stride = 1;
  bit          m_ovf    = 1'b0;
  logic [15:0] m_q[$];

  int          n_xfer    = 0;
  int          n_done    = 0;
  logic [15:0] last_xfer = '0;

  typedef struct {
    int          stride;
    bit          short_pre;
    bit          gaps;
    int          exp_kept;
    logic [15:0] exp_last;
  } line_vec_t;

  line_vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit go, input bit valid, input logic [15:0] din,
                      input logic [3:0] stride, input bit ready);
    bit exp_done;
    GO                 = go;
    bus_if.DIN_VALID   = valid;
    bus_if.DIN         = din;
    STRIDE             = stride;
    bus_if.PIXEL_READY = ready;
    @(negedge CLK);
    exp_done = (m_mode == 2) && valid && (m_idx == PIXELS - 1);
    chk("done", 32'(DONE), 32'(exp_done));
    if (DONE) n_done++;
    if (bus_if.PUSH && ready) begin
      n_xfer++;
      last_xfer = bus_if.PIXEL_DATA;
    end
    if (!RST_N) begin
      m_mode = 0;
      m_ovf  = 1'b0;
      m_q.delete();
    end else begin
      if (ready && m_q.size() > 0) void'(m_q.pop_front());
      case (m_mode)
        0: if (go) begin
          m_mode = 1;
          m_run  = 0;
          m_ovf  = 1'b0;
        end
        1: if (!go) begin
          m_mode = 0;
        end else if (valid) begin
          if (din == PRE) m_run++;
          else if (din == SYNC && m_run >= PRE_LEN) begin
            m_mode   = 2;
            m_idx    = 0;
            m_stride = (stride == 4'd0) ? 1 : int'(stride);
          end else m_run = 0;
        end
        default: if (valid) begin
          if (m_idx % m_stride == 0) begin
            if (m_q.size() < DEPTH) m_q.push_back(din);
            else m_ovf = 1'b1;
          end
          m_idx++;
          if (m_idx == PIXELS) m_mode = 0;
        end
      endcase
    end
    @(posedge CLK);
    #1;
    chk("push", 32'(bus_if.PUSH), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("pixel_data", 32'(bus_if.PIXEL_DATA), 32'(m_q[0]));
    chk("busy", 32'(BUSY), 32'(m_mode != 0));
    chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 4'd1, 1'b1);
  endtask

  // Stride is presented through the sync word, then switched to 1 for the line body.
  task automatic run_line(input int stride, input bit short_pre, input bit gaps, input bit ready);
    logic [15:0] words[$];
    int          hdr;
    if (short_pre) words = '{16'hFFFF, 16'hAAAA, 16'hFFFF, 16'hFFFF, 16'hAAAA};
    else           words = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hAAAA};
    hdr = words.size();
    for (int i = 1; i <= PIXELS; i++) words.push_back(16'(i));
    step(1'b1, 1'b0, 16'h0000, 4'(stride), ready);
    for (int i = 0; i < words.size(); i++) begin
      step(1'b1, 1'b1, words[i], (i < hdr) ? 4'(stride) : 4'd1, ready);
      if (gaps) step(1'b1, 1'b0, 16'hAAAA, 4'd1, ready);
    end
  endtask

  initial begin
    int x0, d0;
    vecs[0] = '{1,  1'b0, 1'b0, 16, 16'h0010};
    vecs[1] = '{1,  1'b1, 1'b0, 16, 16'h0010};
    vecs[2] = '{3,  1'b0, 1'b0, 6,  16'h0010};
    vecs[3] = '{1,  1'b0, 1'b1, 16, 16'h0010};
    vecs[4] = '{0,  1'b0, 1'b0, 16, 16'h0010};
    vecs[5] = '{5,  1'b1, 1'b1, 4,  16'h0010};
    vecs[6] = '{15, 1'b0, 1'b0, 2,  16'h0010};
    vecs[7] = '{4,  1'b0, 1'b0, 4,  16'h000D};

    bus_if.DIN_VALID   = 1'b0;
    bus_if.DIN         = '0;
    bus_if.PIXEL_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_push", 32'(bus_if.PUSH), 32'd0);
    chk("rst_data", 32'(bus_if.PIXEL_DATA), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    RST_N = 1'b1;

    for (int v = 0; v < 8; v++) begin
      x0 = n_xfer;
      d0 = n_done;
      run_line(vecs[v].stride, vecs[v].short_pre, vecs[v].gaps, 1'b1);
      drain(4);
      chk("line_kept", 32'(n_xfer - x0), 32'(vecs[v].exp_kept));
      chk("line_last", 32'(last_xfer), 32'(vecs[v].exp_last));
      chk("line_done", 32'(n_done - d0), 32'd1);
      chk("line_ovf", 32'(OVERFLOW), 32'd0);
    end

    // Sink stalled for the whole line: the first DEPTH words survive.
    x0 = n_xfer;
    run_line(1, 1'b0, 1'b0, 1'b0);
    chk("bp_ovf_set", 32'(OVERFLOW), 32'd1);
    chk("bp_no_xfer", 32'(n_xfer - x0), 32'd0);
    chk("bp_head", 32'(bus_if.PIXEL_DATA), 32'h0001);
    drain(10);
    chk("bp_drained", 32'(n_xfer - x0), 32'd8);
    chk("bp_last", 32'(last_xfer), 32'h0008);
    chk("bp_ovf_sticky", 32'(OVERFLOW), 32'd1);
    step(1'b1, 1'b0, 16'h0000, 4'd1, 1'b1);
    chk("bp_ovf_clear", 32'(OVERFLOW), 32'd0);
    drain(2);

    // Reset after 0005 with the sink stalled, then a clean line with GO held.
    x0 = n_xfer;
    d0 = n_done;
    run_line(1, 1'b0, 1'b0, 1'b0);
    drain(1);
    x0 = n_xfer;
    d0 = n_done;
    step(1'b1, 1'b0, 16'h0000, 4'd1, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 4'd1, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 4'd1, 1'b0);
    step(1'b1, 1'b1, 16'hAAAA, 4'd1, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 16'(i), 4'd1, 1'b0);
    chk("mid_push_before", 32'(bus_if.PUSH), 32'd1);
    RST_N = 1'b0;
    step(1'b1, 1'b1, 16'h0006, 4'd1, 1'b0);
    RST_N = 1'b1;
    chk("mid_rst_push", 32'(bus_if.PUSH), 32'd0);
    chk("mid_rst_data", 32'(bus_if.PIXEL_DATA), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    run_line(1, 1'b0, 1'b0, 1'b1);
    drain(4);
    chk("mid_kept", 32'(n_xfer - x0), 32'd16);
    chk("mid_last", 32'(last_xfer), 32'h0010);
    chk("mid_done", 32'(n_done - d0), 32'd1);

    // Random noisy headers, gaps, strides and sink stalls.
    for (int l = 0; l < 12; l++) begin
      int nh, nd, pick;
      logic [15:0] w;
      step(1'b1, 1'b0, 16'h0000, 4'd1, 1'b1);
      nh = $urandom_range(0, 6);
      for (int i = 0; i < nh; i++) begin
        pick = $urandom_range(0, 2);
        w = (pick == 0) ? PRE : (pick == 1) ? SYNC : 16'($urandom_range(0, 16'h7FFF));
        step(1'b1, $urandom_range(0, 3) != 0, w, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      end
      step(1'b1, 1'b1, PRE, 4'($urandom_range(0, 15)), 1'b1);
      step(1'b1, 1'b1, PRE, 4'($urandom_range(0, 15)), 1'b1);
      step(1'b1, 1'b1, SYNC, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      nd = 0;
      while (nd < PIXELS + 2) begin
        bit vld;
        vld = $urandom_range(0, 3) != 0;
        if (vld) nd++;
        step(1'b1, vld, 16'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      end
      drain(DEPTH + 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
